seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Four-digit time-multiplexed scan driver sitting directly upstream of the `seg7v` nibble-to-segment decoder. It holds a 16-bit display value, steps through its four nibbles at a programmable refresh rate, and presents one nibble per slot on `nibble` together with a matching one-hot anode enable. Updates from the producer are applied only at frame boundaries, so the display never shows a mix of old and new digits.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥1.
- `ANODE_ACTIVE_LOW`, default 1: 1 means an enabled digit drives 0 on `an`; 0 means it drives 1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `value`  in  16  display value; digit k is `value[4k+3:4k]`, digit 0 is rightmost.
- `load`  in  1  one-cycle strobe that captures `value`.
- `nibble`  out  4  current digit's nibble; feeds `seg7v.nibble`.
- `an`  out  4  anode enables, one-hot at the active level; delayed one cycle to align with `seg7v`'s registered `seg`.
- `digit_sel`  out  2  index of the digit currently on `nibble`.
- `frame`  out  1  one-cycle pulse when the scan wraps from 3 to 0.

## Operation
- Prescaler `div_q` counts 0..REFRESH_DIV-1. A tick occurs when `div_q == REFRESH_DIV-1`; on the tick `div_q` returns to 0.
- On each tick, `digit_sel` increments modulo 4.
- `nibble` is registered. It updates on the same edge as `digit_sel` and takes the display-register digit for the new index.
- `frame` is 1 for exactly the cycle after the tick on which `digit_sel` goes 3 to 0.
- Load path:
  - `load` = 1 writes `value` into `pend_q` and sets `pend_v`.
  - On a wrap tick with `pend_v` = 1, `disp_q` takes `pend_q` and `pend_v` clears.
  - On a wrap tick with `load` = 1 in the same cycle, `disp_q` takes `value` directly and `pend_v` stays 0.
  - Multiple loads within one frame: only the last is kept.
- On the wrap edge, `nibble` takes digit 0 of the **new** `disp_q`.
- `an` is registered from `digit_sel` and the blank mask, one cycle behind `nibble`. A digit that is not enabled drives the inactive level.

## Timing
- Reset values:
  - `div_q` = 0, `digit_sel` = 0, `nibble` = 0, `frame` = 0.
  - `disp_q` = 0, `pend_q` = 0, `pend_v` = 0.
  - `an` = all inactive (4'b1111 when `ANODE_ACTIVE_LOW` = 1).
- First cycle after reset release: `an` enables digit 0.
- Latency:
  - Load to visible: at most 4·REFRESH_DIV cycles.
  - `nibble` to `an`: exactly 1 cycle.
- Full frame period: 4·REFRESH_DIV cycles.
- `REFRESH_DIV` = 1: a tick every cycle; `digit_sel` advances every cycle.
- Reset asserted mid-frame: all state returns to reset values on that edge. Any pending load is discarded.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digits above the most significant non-zero nibble of `disp_q` drive the inactive anode level. The prescaler and scan timing are unchanged.
  - Digit 0 is always enabled, so `disp_q` = 0 shows "0".
- Undefined: every digit is enabled in its slot regardless of value.

## Structure
- Package `seg7_pkg` holds:
  - `NUM_DIGITS` = 4.
  - Typedef `digit_idx_t` (2 bits).
  - Function `anode_onehot(idx, active_low)`.
  - Function `lz_mask(value)`, returning a 4-bit enable mask.
- Sub-module `seg7_prescaler(clk, rst, tick)`, parameterised by `REFRESH_DIV`.
- `seg7_scan_mux` instantiates the prescaler and contains the index counter, the load/shadow registers and the output registers.

## Test plan
All scenarios use `REFRESH_DIV` = 4 and `ANODE_ACTIVE_LOW` = 1 unless stated.
- Reset, then release:
  - During reset, `an` = 1111, `nibble` = 0 and `frame` = 0.
  - First cycle after release, `an` = 1110.
- Load 16'h2583, wait one frame:
  - `nibble` sequence is 3, 8, 5, 2, each held 4 cycles.
  - `an` is 1110, 1101, 1011, 0111, each lagging `nibble` by 1 cycle.
  - `frame` pulses every 16 cycles.
- Mid-frame tearing:
  - Load 16'h1111, then load 16'hABCD while `digit_sel` = 1.
  - The rest of the frame shows 1; the next frame shows D, C, B, A.
- Coincident load: load 16'h0F0F in the wrap-tick cycle → digit 0 of the new frame is F.
- Leading-zero blanking:
  - With `SEG7_LZ_BLANK_EN` defined and load 16'h0042, digits 2–3 stay 1 on `an`; digits 0–1 scan normally.
  - Load 16'h0000 → only digit 0 is enabled and `nibble` = 0.
- Reset mid-frame and minimum divider:
  - Assert `rst` during digit 2 with a load pending → `digit_sel` = 0 and `disp_q` = 0; the pending value is never shown.
  - With `REFRESH_DIV` = 1, `digit_sel` increments every cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the four-digit seven-segment scan driver.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [1:0] digit_idx_t;

   function automatic logic [3:0] anode_onehot(
      input digit_idx_t idx,
      input logic       active_low
   );
      logic [3:0] oh;
      oh = 4'b0001 << idx;
      return active_low ? ~oh : oh;
   endfunction

   // Enable every digit up to the most significant non-zero nibble.
   function automatic logic [3:0] lz_mask(input logic [15:0] value);
      logic [3:0] m;
      if (value[15:12] != 4'h0)
         m = 4'b1111;
      else if (value[11:8] != 4'h0)
         m = 4'b0111;
      else if (value[7:4] != 4'h0)
         m = 4'b0011;
      else
         m = 4'b0001;
      return m;
   endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Refresh prescaler: one tick every REFRESH_DIV clock cycles.
module seg7_prescaler #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(REFRESH_DIV - 1);

   logic [W-1:0] div_q;
   logic [W-1:0] div_d;

   always_comb begin
      tick  = (div_q == LAST);
      div_d = tick ? '0 : div_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         div_q <= '0;
      else
         div_q <= div_d;
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit scan multiplexer with frame-aligned display updates.
// Optional leading-zero blanking: define SEG7_LZ_BLANK_EN.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV      = 50000,
   parameter int ANODE_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        load,
   output logic [3:0]  nibble,
   output logic [3:0]  an,
   output logic [1:0]  digit_sel,
   output logic        frame
);

   localparam logic AN_LOW = (ANODE_ACTIVE_LOW != 0);
   localparam logic [3:0] AN_OFF = AN_LOW ? 4'hF : 4'h0;

   logic        tick;
   logic        wrap;
   logic [3:0]  en_mask;

   digit_idx_t  sel_q, sel_d;
   logic [3:0]  nibble_q, nibble_d;
   logic [3:0]  an_q, an_d;
   logic        frame_q, frame_d;
   logic [15:0] disp_q, disp_d;
   logic [15:0] pend_q, pend_d;
   logic        pend_v_q, pend_v_d;

   seg7_prescaler #(
      .REFRESH_DIV(REFRESH_DIV)
   ) u_presc (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   always_comb begin
      sel_d    = sel_q;
      nibble_d = nibble_q;
      disp_d   = disp_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      wrap     = tick && (sel_q == 2'd3);

      if (load) begin
         pend_d   = value;
         pend_v_d = 1'b1;
      end

      // A load landing on the wrap edge bypasses the shadow register.
      if (wrap) begin
         pend_v_d = 1'b0;
         if (load)
            disp_d = value;
         else if (pend_v_q)
            disp_d = pend_q;
      end

      if (tick) begin
         sel_d    = sel_q + 2'd1;
         nibble_d = disp_d[{sel_d, 2'b00} +: 4];
      end

      frame_d = wrap;

`ifdef SEG7_LZ_BLANK_EN
      en_mask = lz_mask(disp_q);
`else
      en_mask = 4'hF;
`endif

      an_d = en_mask[sel_q] ? anode_onehot(sel_q, AN_LOW) : AN_OFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q    <= '0;
         nibble_q <= '0;
         an_q     <= AN_OFF;
         frame_q  <= 1'b0;
         disp_q   <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
      end else begin
         sel_q    <= sel_d;
         nibble_q <= nibble_d;
         an_q     <= an_d;
         frame_q  <= frame_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
      end
   end

   assign nibble    = nibble_q;
   assign an        = an_q;
   assign digit_sel = sel_q;
   assign frame     = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux (REFRESH_DIV 4 and 1).
module tb_seg7_scan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic        load;
   logic [3:0]  nibble;
   logic [3:0]  an;
   logic [1:0]  sel;
   logic        frame;

   logic        rst1;
   logic        load1;
   logic [3:0]  nibble1;
   logic [3:0]  an1;
   logic [1:0]  sel1;
   logic        frame1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg7_scan_mux #(
      .REFRESH_DIV(4),
      .ANODE_ACTIVE_LOW(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .value    (value),
      .load     (load),
      .nibble   (nibble),
      .an       (an),
      .digit_sel(sel),
      .frame    (frame)
   );

   seg7_scan_mux #(
      .REFRESH_DIV(1),
      .ANODE_ACTIVE_LOW(1)
   ) dut1 (
      .clk      (clk),
      .rst      (rst1),
      .value    (value),
      .load     (load1),
      .nibble   (nibble1),
      .an       (an1),
      .digit_sel(sel1),
      .frame    (frame1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      step();
      while (frame !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      if (frame !== 1'b1) begin
         checks++;
         failures++;
         $error("FAIL frame_timeout observed=%b expected=1", frame);
      end
   endtask

   function automatic logic [3:0] dig(input logic [15:0] v, input int d);
      return 4'((v >> (4 * d)) & 16'h000F);
   endfunction

   // Expected active-low anode pattern for slot d with display value v.
   function automatic logic [3:0] exp_an(input int d, input logic [15:0] v);
      logic en;
`ifdef SEG7_LZ_BLANK_EN
      en = (d == 0) || ((v >> (4 * d)) != 16'h0);
`else
      en = 1'b1;
`endif
      return en ? ~(4'b0001 << d) : 4'b1111;
   endfunction

   initial begin
      rst = 1'b1;
      rst1 = 1'b1;
      load = 1'b0;
      load1 = 1'b0;
      value = 16'h0;
      step();
      step();
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_nibble", 16'(nibble), 16'h0);
      chk("rst_frame", 16'(frame), 16'h0);
      chk("rst_sel", 16'(sel), 16'h0);
      rst = 1'b0;
      step();
      chk("release_an", 16'(an), 16'hE);

      value = 16'h2583;
      load = 1'b1;
      step();
      load = 1'b0;
      wait_frame();
      for (int k = 0; k < 16; k++) begin
         chk("f1_nibble", 16'(nibble), 16'(dig(16'h2583, k / 4)));
         if (k == 0)
            chk("f1_an0", 16'(an), 16'h7);
         else
            chk("f1_an", 16'(an), 16'(exp_an((k - 1) / 4, 16'h2583)));
         if (k != 0)
            chk("f1_frame_low", 16'(frame), 16'h0);
         step();
      end
      chk("f1_frame_period", 16'(frame), 16'h1);

      value = 16'h1111;
      load = 1'b1;
      step();
      load = 1'b0;
      wait_frame();
      for (int k = 0; k < 4; k++) step();
      chk("tear_sel1", 16'(sel), 16'h1);
      value = 16'hABCD;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 5; k < 16; k++) begin
         chk("tear_old", 16'(nibble), 16'h1);
         step();
      end
      chk("tear_frame", 16'(frame), 16'h1);
      for (int k = 0; k < 16; k++) begin
         chk("tear_new", 16'(nibble), 16'(dig(16'hABCD, k / 4)));
         step();
      end

      for (int k = 0; k < 15; k++) step();
      chk("coin_sel3", 16'(sel), 16'h3);
      value = 16'h0F0F;
      load = 1'b1;
      step();
      load = 1'b0;
      chk("coin_frame", 16'(frame), 16'h1);
      chk("coin_d0", 16'(nibble), 16'hF);
      for (int k = 0; k < 4; k++) step();
      chk("coin_d1", 16'(nibble), 16'h0);
      for (int k = 0; k < 4; k++) step();
      chk("coin_d2", 16'(nibble), 16'hF);

      value = 16'h0042;
      load = 1'b1;
      step();
      load = 1'b0;
      wait_frame();
      for (int k = 0; k < 16; k++) begin
         chk("lz42_nibble", 16'(nibble), 16'(dig(16'h0042, k / 4)));
         if (k != 0)
            chk("lz42_an", 16'(an), 16'(exp_an((k - 1) / 4, 16'h0042)));
         step();
      end

      value = 16'h0000;
      load = 1'b1;
      step();
      load = 1'b0;
      wait_frame();
      for (int k = 0; k < 16; k++) begin
         chk("lz0_nibble", 16'(nibble), 16'h0);
         if (k != 0)
            chk("lz0_an", 16'(an), 16'(exp_an((k - 1) / 4, 16'h0000)));
         step();
      end

      value = 16'h9999;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 8; k++) step();
      chk("mid_sel2", 16'(sel), 16'h2);
      rst = 1'b1;
      step();
      chk("mid_rst_sel", 16'(sel), 16'h0);
      chk("mid_rst_nibble", 16'(nibble), 16'h0);
      chk("mid_rst_frame", 16'(frame), 16'h0);
      chk("mid_rst_an", 16'(an), 16'hF);
      rst = 1'b0;
      step();
      chk("mid_rel_an", 16'(an), 16'hE);
      wait_frame();
      for (int k = 0; k < 16; k++) begin
         chk("mid_discard", 16'(nibble), 16'h0);
         step();
      end

      step();
      rst1 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("div1_sel", 16'(sel1), 16'(k % 4));
         chk("div1_frame", 16'(frame1), 16'((k % 4) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
